fetch_queue: RTL
================

# fetch_queue

Parametrised instruction-fetch stage for the primus core: owns the program counter and drives a synchronous-read instruction memory (1-cycle read latency). It buffers fetched instructions in a small queue and hands them to decode over a valid/ready handshake. It supports back-pressure, branch/jump redirects that flush in-flight and queued fetches, and a configurable reset vector. It sits between the instruction BRAM and the decode stage, replacing the fixed, handshake-free fetch path.

## Interface
- XLEN, 32, datapath and PC width.
- ADDR_W, 10, word-address width presented to instruction memory.
- DEPTH, 2, instruction queue entries; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP, 32'h0000_0013, value driven on id_ir_o when the queue is empty.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
- redirect_i  in  1  redirect request from execute/branch logic.
- redirect_pc_i  in  XLEN  redirect target.
- imem_req_o  out  1  read enable to instruction memory.
- imem_addr_o  out  ADDR_W  word address, pc_q[ADDR_W+1:2].
- imem_rdata_i  in  32  read data, valid the cycle after a request.
- id_valid_o  out  1  queue head holds a valid instruction.
- id_ready_i  in  1  decode accepts head this cycle.
- id_ir_o  out  32  head instruction; NOP when empty.
- id_pc_o  out  XLEN  PC of head instruction.
- id_npc_o  out  XLEN  id_pc_o + 4, modulo 2^XLEN.

## Operation
- State:
  - pc_q: next fetch address.
  - inflight_q: 1 bit; a request was issued last cycle.
  - req_pc_q: PC of the in-flight request.
  - A DEPTH-entry FIFO of {pc, ir}, with read/write pointers and a count of width $clog2(DEPTH)+1.
- Pop: id_valid_o && id_ready_i.
- Issue condition: !rst_i && !redirect_i && (count + inflight_q − pop) < DEPTH. This credit rule guarantees the FIFO never overflows.
- On issue:
  - imem_req_o=1.
  - req_pc_q←pc_q, inflight_q←1.
  - pc_q←pc_q+4, wrapping modulo 2^XLEN.
- When not issuing: inflight_q←0 and pc_q holds.
- Response: when inflight_q=1 and no redirect this cycle, {req_pc_q, imem_rdata_i} is pushed into the FIFO at the cycle end.
- Pop and push in the same cycle are both performed, and count is unchanged.
- Redirect (redirect_i=1 in cycle N):
  - No issue in cycle N.
  - Any response arriving in N is discarded.
  - The FIFO is flushed: pointers and count go to 0.
  - inflight_q←0.
  - pc_q←{redirect_pc_i[XLEN-1:2], 2'b00}; the low bits are forced to zero.
  - A pop in the same cycle is still treated as accepted by decode; redirect takes priority over push.
- Back-pressure: while id_ready_i=0 the head and all id_* outputs stay stable, and fetch stalls once credits are exhausted.
- Outputs when empty: id_valid_o=0, id_ir_o=NOP, id_pc_o and id_npc_o hold the last head value (0 after reset).

## Timing
- Reset (asynchronous assert, synchronous release):
  - pc_q=RESET_PC, inflight_q=0, FIFO empty.
  - imem_req_o=0, imem_addr_o=RESET_PC[ADDR_W+1:2].
  - id_valid_o=0, id_ir_o=NOP, id_pc_o=0, id_npc_o=4.
- First cycle after reset release: imem_req_o=1 with address RESET_PC.
- Fetch-to-decode latency is 2 cycles: request in C, data in C+1, FIFO write at end of C+1, id_valid_o in C+2.
- No bypass.
- Throughput: with DEPTH ≥ 2 and id_ready_i held at 1, one instruction per cycle is sustained indefinitely.
- Redirect in N:
  - N+1: imem_req_o=1 at the target, id_valid_o=0.
  - N+3: first target instruction visible at decode.
- Back-to-back redirects: each redirect restarts the sequence above; only the last target is fetched.
- Reset asserted mid-operation: all state is cleared immediately; in-flight data is ignored after release.

## Test plan
- Reset release with RESET_PC=0 and memory word k = 0x1000+k, ready=1:
  - imem_addr_o = 0,1,2,… on consecutive cycles.
  - id_valid_o rises 2 cycles after release.
  - id_ir_o/id_pc_o = 0x1000/0, 0x1001/4, … one per cycle.
- Stall: drop id_ready_i for 5 cycles mid-stream:
  - id_* stable throughout; imem_req_o deasserts once count+inflight=DEPTH.
  - On resume, no instruction is lost or duplicated and PCs stay contiguous.
- Redirect to 0x0000_0103 while the FIFO is full and a fetch is in flight:
  - The next request address is word 0x40.
  - id_valid_o=0 for 2 cycles, then id_pc_o=0x100.
  - No stale instruction appears.
- Redirect coincident with a pop, then a second redirect the following cycle:
  - Only the second target is ever presented to decode.
- PC wrap: redirect to 0xFFFF_FFFC:
  - The next fetch is at PC 0; id_npc_o=0 for the 0xFFFF_FFFC entry.
- Reset asserted while the FIFO holds 2 entries:
  - Outputs return to their reset values asynchronously.
  - After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and buffers returned words in a small FIFO feeding decode over valid/ready.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 10,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [31:0]       id_ir_o,
    output logic [XLEN-1:0]   id_pc_o,
    output logic [XLEN-1:0]   id_npc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     ir;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [XLEN-1:0]   pc_q, req_pc_q, last_pc_q;
    logic              inflight_q;

    logic              pop, push, issue;
    logic [CNT_W:0]    credits;
    entry_t            head;

    assign head       = fifo_q[rd_ptr_q];
    assign id_valid_o = (count_q != '0);
    assign id_ir_o    = id_valid_o ? head.ir : NOP;
    assign id_pc_o    = id_valid_o ? head.pc : last_pc_q;
    assign id_npc_o   = id_pc_o + XLEN'(4);

    assign pop  = id_valid_o && id_ready_i;
    assign push = inflight_q && !redirect_i;

    // Credits count every slot already committed: queued, in flight, minus what leaves now.
    assign credits = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}
                   - {{CNT_W{1'b0}}, pop};
    assign issue   = !rst_i && !redirect_i && (credits < (CNT_W+1)'(DEPTH));

    assign imem_req_o  = issue;
    assign imem_addr_o = pc_q[ADDR_W+1:2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            last_pc_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue)
                req_pc_q <= pc_q;

            if (redirect_i)
                pc_q <= redirect_pc_i & ~XLEN'(3);
            else if (issue)
                pc_q <= pc_q + XLEN'(4);

            // Remember the head so id_pc_o holds its last value once the queue drains.
            if (id_valid_o)
                last_pc_q <= head.pc;

            if (redirect_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push)
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            fifo_q[wr_ptr_q] <= '{pc: req_pc_q, ir: imem_rdata_i};
    end

endmodule
